// File: rtl/score_tracker.sv
// score_tracker: Pong score bookkeeping.
// Three asynchronous event inputs are synchronised into ClkPort and edge detected.
// A four-state game FSM keeps a packed-BCD running score and a BCD high score.
// Every output is a register, so no combinational path runs from an input to an output.
module score_tracker #(
    parameter int SYNC_STAGES = 2,
    parameter int HIT_POINTS  = 1
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic        hit,
    input  logic        miss,
    input  logic        ack,
    output logic [15:0] score,
    output logic [15:0] highscore,
    output logic        game_over,
    output logic        new_record
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CHECK = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [3:0] HIT_BCD = 4'(HIT_POINTS);

    state_t                 state_r;
    logic [SYNC_STAGES-1:0] hit_sync_r;
    logic [SYNC_STAGES-1:0] miss_sync_r;
    logic [SYNC_STAGES-1:0] ack_sync_r;
    logic                   hit_hist_r;
    logic                   miss_hist_r;
    logic                   ack_hist_r;
    logic                   hit_rise_s;
    logic                   miss_rise_s;
    logic                   ack_rise_s;

    // Packed-BCD add of a single digit to the units position.
    // A carry out of the thousands digit saturates the result at 9999.
    function automatic logic [15:0] bcd_add(input logic [15:0] val, input logic [3:0] pts);
        logic [4:0]  digit;
        logic [3:0]  addend;
        logic        carry;
        logic [15:0] res;
        carry = 1'b0;
        res   = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            addend = (i == 0) ? pts : 4'd0;
            digit  = {1'b0, val[i*4 +: 4]} + {1'b0, addend} + {4'b0000, carry};
            if (digit > 5'd9) begin
                digit = digit - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            res[i*4 +: 4] = digit[3:0];
        end
        if (carry) begin
            res = 16'h9999;
        end
        return res;
    endfunction

    // Synchroniser chains and edge-history flops; reset high so a held level gives no edge.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            hit_sync_r  <= '1;
            miss_sync_r <= '1;
            ack_sync_r  <= '1;
            hit_hist_r  <= 1'b1;
            miss_hist_r <= 1'b1;
            ack_hist_r  <= 1'b1;
        end else begin
            hit_sync_r  <= {hit_sync_r[SYNC_STAGES-2:0], hit};
            miss_sync_r <= {miss_sync_r[SYNC_STAGES-2:0], miss};
            ack_sync_r  <= {ack_sync_r[SYNC_STAGES-2:0], ack};
            hit_hist_r  <= hit_sync_r[SYNC_STAGES-1];
            miss_hist_r <= miss_sync_r[SYNC_STAGES-1];
            ack_hist_r  <= ack_sync_r[SYNC_STAGES-1];
        end
    end

    assign hit_rise_s  = hit_sync_r[SYNC_STAGES-1]  & ~hit_hist_r;
    assign miss_rise_s = miss_sync_r[SYNC_STAGES-1] & ~miss_hist_r;
    assign ack_rise_s  = ack_sync_r[SYNC_STAGES-1]  & ~ack_hist_r;

    // Game FSM with registered score, high score and status outputs.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state_r    <= IDLE;
            score      <= 16'h0000;
            highscore  <= 16'h0000;
            game_over  <= 1'b0;
            new_record <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ack_rise_s) begin
                        state_r <= PLAY;
                        score   <= 16'h0000;
                    end
                end
                PLAY: begin
                    // A hit arriving together with a miss still counts.
                    if (hit_rise_s) begin
                        score <= bcd_add(score, HIT_BCD);
                    end
                    if (miss_rise_s) begin
                        state_r <= CHECK;
                    end
                end
                CHECK: begin
                    // Raw 16-bit compare is valid: packed BCD preserves numeric order.
                    state_r   <= OVER;
                    game_over <= 1'b1;
                    if (score > highscore) begin
                        highscore  <= score;
                        new_record <= 1'b1;
                    end else begin
                        new_record <= 1'b0;
                    end
                end
                OVER: begin
                    if (ack_rise_s) begin
                        state_r    <= PLAY;
                        score      <= 16'h0000;
                        game_over  <= 1'b0;
                        new_record <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    score      <= 16'h0000;
                    game_over  <= 1'b0;
                    new_record <= 1'b0;
                end
            endcase
        end
    end

endmodule
